// File: rtl/led_step_controller.sv
// Step sequencer for the LED datapath: programmable prescaler producing step ticks,
// a WIDTH-bit pattern advanced per tick, and an IDLE/RUN/PAUSE run-state machine.
module led_step_controller #(
    parameter int INPUT_CLOCK    = 27000000,
    parameter int STEP_RATE      = 2,
    parameter int DEFAULT_PERIOD = INPUT_CLOCK / STEP_RATE,
    parameter int PERIOD_BITS    = 32,
    parameter int WIDTH          = 6,
    parameter int LED_ACTIVE_LOW = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [PERIOD_BITS-1:0] cfg_period,
    input  logic [1:0]             cfg_mode,
    input  logic                   start,
    input  logic                   pause,
    input  logic                   stop,
    output logic                   step_tick,
    output logic                   busy,
    output logic [WIDTH-1:0]       pattern,
    output logic [WIDTH-1:0]       led
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [PERIOD_BITS-1:0] P_ONE     = {{(PERIOD_BITS-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_BITS-1:0] P_DEFAULT = PERIOD_BITS'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0]       W_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]       LED_RESET = (LED_ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    localparam logic                   DIR_LEFT  = 1'b0;
    localparam logic                   DIR_RIGHT = 1'b1;

    function automatic logic [WIDTH-1:0] init_pattern(input logic [1:0] m);
        case (m)
            2'b00:   return {WIDTH{1'b0}};
            2'b01:   return {WIDTH{1'b1}};
            default: return W_ONE;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] map_led(input logic [WIDTH-1:0] p);
        return (LED_ACTIVE_LOW != 0) ? ~p : p;
    endfunction

    state_t                   state;
    logic [PERIOD_BITS-1:0]   period;
    logic [PERIOD_BITS-1:0]   prescaler;
    logic [1:0]               mode;
    logic                     dir;

    logic [PERIOD_BITS-1:0]   eff_period;
    logic                     terminal;
    logic                     accept;
    logic [1:0]               mode_eff;
    logic [WIDTH-1:0]         next_pattern;
    logic                     next_dir;

    // Prescaler terminal detect and config handshake decode
    always_comb begin
        eff_period = (period == {PERIOD_BITS{1'b0}}) ? P_ONE : period;
        terminal   = (prescaler == (eff_period - P_ONE));
        accept     = cfg_valid && cfg_ready;
        mode_eff   = accept ? cfg_mode : mode;
    end

    // Next pattern for one step in the current mode
    always_comb begin
        next_pattern = pattern;
        next_dir     = dir;
        case (mode)
            2'b00: next_pattern = pattern + W_ONE;
            2'b01: next_pattern = pattern - W_ONE;
            2'b10: next_pattern = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
            2'b11: begin
                if (dir == DIR_LEFT) begin
                    next_pattern = {pattern[WIDTH-2:0], 1'b0};
                    next_dir     = next_pattern[WIDTH-1] ? DIR_RIGHT : DIR_LEFT;
                end else begin
                    next_pattern = {1'b0, pattern[WIDTH-1:1]};
                    next_dir     = next_pattern[0] ? DIR_LEFT : DIR_RIGHT;
                end
            end
            default: next_pattern = pattern;
        endcase
    end

    // Run-state machine, prescaler, pattern and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            period    <= P_DEFAULT;
            mode      <= 2'b00;
            prescaler <= {PERIOD_BITS{1'b0}};
            pattern   <= {WIDTH{1'b0}};
            dir       <= DIR_LEFT;
            step_tick <= 1'b0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            led       <= LED_RESET;
        end else begin
            step_tick <= 1'b0;
            if (accept) begin
                period    <= cfg_period;
                mode      <= cfg_mode;
                prescaler <= {PERIOD_BITS{1'b0}};
            end
            if (stop) begin
                state     <= IDLE;
                prescaler <= {PERIOD_BITS{1'b0}};
                pattern   <= init_pattern(mode_eff);
                led       <= map_led(init_pattern(mode_eff));
                dir       <= DIR_LEFT;
                busy      <= 1'b0;
                cfg_ready <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (!pause && start) begin
                            state     <= RUN;
                            prescaler <= {PERIOD_BITS{1'b0}};
                            pattern   <= init_pattern(mode_eff);
                            led       <= map_led(init_pattern(mode_eff));
                            dir       <= DIR_LEFT;
                            busy      <= 1'b1;
                            cfg_ready <= 1'b0;
                        end
                    end
                    RUN: begin
                        // Pause beats a coincident terminal count; count stays at eff_period-1
                        if (pause) begin
                            state     <= PAUSE;
                            cfg_ready <= 1'b1;
                        end else if (terminal) begin
                            prescaler <= {PERIOD_BITS{1'b0}};
                            step_tick <= 1'b1;
                            pattern   <= next_pattern;
                            led       <= map_led(next_pattern);
                            dir       <= next_dir;
                        end else begin
                            prescaler <= prescaler + P_ONE;
                        end
                    end
                    PAUSE: begin
                        if (!pause && start) begin
                            state     <= RUN;
                            cfg_ready <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_step_controller.sv
// Directed bench for led_step_controller: expected step ticks (edge number and pattern)
// are queued when a run is started and popped when the DUT pulses step_tick.
module tb_led_step_controller;

    localparam int PB = 32;
    localparam int W  = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [PB-1:0] cfg_period;
    logic [1:0]    cfg_mode;
    logic          start;
    logic          pause;
    logic          stop;
    logic          step_tick;
    logic          busy;
    logic [W-1:0]  pattern;
    logic [W-1:0]  led;

    typedef struct {
        int           edge_no;
        logic [W-1:0] pat;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    int   b;
    int   pp_seq [11] = '{2, 4, 8, 16, 32, 16, 8, 4, 2, 1, 2};

    led_step_controller #(
        .INPUT_CLOCK(20), .STEP_RATE(2), .PERIOD_BITS(PB), .WIDTH(W), .LED_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_period(cfg_period), .cfg_mode(cfg_mode), .start(start), .pause(pause),
        .stop(stop), .step_tick(step_tick), .busy(busy), .pattern(pattern), .led(led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_tick(input int edge_no, input logic [W-1:0] p);
        exp_t e;
        e.edge_no = edge_no;
        e.pat     = p;
        q.push_back(e);
    endtask

    task automatic step();
        exp_t         e;
        logic [W-1:0] exp_led;
        @(posedge clk);
        edge_cnt++;
        #1;
        if (step_tick === 1'b1 || (q.size() > 0 && q[0].edge_no == edge_cnt)) begin
            if (q.size() == 0) begin
                check("unexpected_tick", {31'd0, step_tick}, 32'd0);
            end else begin
                e       = q.pop_front();
                exp_led = ~e.pat;
                check("tick_pulse", {31'd0, step_tick}, 32'd1);
                check("tick_edge", edge_cnt, e.edge_no);
                check("tick_pattern", {26'd0, pattern}, {26'd0, e.pat});
                check("tick_led", {26'd0, led}, {26'd0, exp_led});
            end
        end
    endtask

    task automatic do_cfg(input logic [PB-1:0] p, input logic [1:0] m);
        cfg_valid  = 1'b1;
        cfg_period = p;
        cfg_mode   = m;
        step();
        cfg_valid  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_period = 32'd0; cfg_mode = 2'b00;
        start = 1'b0; pause = 1'b0; stop = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_tick", {31'd0, step_tick}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, cfg_ready}, 32'd1);
        check("rst_pattern", {26'd0, pattern}, 32'd0);
        check("rst_led", {26'd0, led}, 32'h3F);

        // 1: period 4 count-up
        do_cfg(32'd4, 2'b00);
        b = edge_cnt + 1;
        push_tick(b + 4, 6'd1); push_tick(b + 8, 6'd2); push_tick(b + 12, 6'd3);
        pulse_start();
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_ready_run", {31'd0, cfg_ready}, 32'd0);
        for (int i = 0; i < 12; i++) step();
        check("t1_drained", q.size(), 32'd0);
        pulse_stop();
        check("t1_stop_busy", {31'd0, busy}, 32'd0);

        // 2: period 1 count-up wraps through 63 to 0
        do_cfg(32'd1, 2'b00);
        b = edge_cnt + 1;
        for (int i = 1; i <= 64; i++) push_tick(b + i, W'(i % 64));
        pulse_start();
        for (int i = 0; i < 64; i++) step();
        check("t2_drained", q.size(), 32'd0);
        check("t2_wrap", {26'd0, pattern}, 32'd0);
        pulse_stop();

        // 3: ping-pong period 2
        do_cfg(32'd2, 2'b11);
        b = edge_cnt + 1;
        for (int i = 0; i < 11; i++) push_tick(b + 2 * (i + 1), W'(pp_seq[i]));
        pulse_start();
        check("t3_init", {26'd0, pattern}, 32'd1);
        for (int i = 0; i < 22; i++) step();
        check("t3_drained", q.size(), 32'd0);
        pulse_stop();

        // 4: period 5 count-down, pause on the terminal-count edge
        do_cfg(32'd5, 2'b01);
        b = edge_cnt + 1;
        pulse_start();
        check("t4_init", {26'd0, pattern}, 32'h3F);
        for (int i = 0; i < 4; i++) step();
        pause = 1'b1;
        step();
        pause = 1'b0;
        check("t4_pause_ready", {31'd0, cfg_ready}, 32'd1);
        check("t4_pause_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            step();
            check("t4_hold", {26'd0, pattern}, 32'h3F);
        end
        push_tick(edge_cnt + 2, 6'd62);
        pulse_start();
        step();
        check("t4_drained", q.size(), 32'd0);
        pulse_stop();

        // 5: config ignored in RUN; stop beats start
        do_cfg(32'd3, 2'b00);
        b = edge_cnt + 1;
        push_tick(b + 3, 6'd1); push_tick(b + 6, 6'd2);
        pulse_start();
        step();
        cfg_valid = 1'b1; cfg_period = 32'd7; cfg_mode = 2'b01;
        check("t5_ready_run", {31'd0, cfg_ready}, 32'd0);
        step();
        cfg_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("t5_drained", q.size(), 32'd0);
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        check("t5_idle_busy", {31'd0, busy}, 32'd0);
        check("t5_idle_ready", {31'd0, cfg_ready}, 32'd1);
        check("t5_init", {26'd0, pattern}, 32'd0);
        check("t5_tick_low", {31'd0, step_tick}, 32'd0);
        for (int i = 0; i < 3; i++) step();

        // 6: period 0 acts as 1; async reset mid-run restores defaults
        do_cfg(32'd0, 2'b00);
        b = edge_cnt + 1;
        push_tick(b + 1, 6'd1); push_tick(b + 2, 6'd2); push_tick(b + 3, 6'd3);
        pulse_start();
        for (int i = 0; i < 3; i++) step();
        check("t6_drained", q.size(), 32'd0);
        rst = 1'b1;
        #2;
        check("t6_rst_tick", {31'd0, step_tick}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_ready", {31'd0, cfg_ready}, 32'd1);
        check("t6_rst_pattern", {26'd0, pattern}, 32'd0);
        check("t6_rst_led", {26'd0, led}, 32'h3F);
        #1;
        rst = 1'b0;
        step();
        b = edge_cnt + 1;
        push_tick(b + 10, 6'd1);
        pulse_start();
        for (int i = 0; i < 10; i++) step();
        check("t6_default_period", q.size(), 32'd0);
        pulse_stop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
